icache_req_arbiter: RTL and testbench
=====================================

Name: icache_req_arbiter

Overview:
- Shares one instruction-cache request/response port among NUM_REQS fetch requesters (e.g. the warp-scheduler fetch path, a prefetcher, a debug fetch port).
- Round-robin grant, one registered request stage, per-requester outstanding-request limiting, and response routing by a requester index appended to the tag.
- Sits between the fetch-side requesters and the icache request/response interfaces.

Parameters:
- NUM_REQS, 2: number of requesters (>=1).
- ADDR_WIDTH, 30: word address width.
- DATA_WIDTH, 32: response data width.
- TAG_WIDTH, 8: requester-side tag width.
- MAX_OUTST, 4: maximum in-flight requests per requester (>=1).
- SEL_BITS, derived as max(1, clog2(NUM_REQS)): requester index width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQS  per-requester request valid.
- req_addr  in  NUM_REQS*ADDR_WIDTH  per-requester address; requester i occupies slice i.
- req_tag  in  NUM_REQS*TAG_WIDTH  per-requester tag.
- req_ready  out  NUM_REQS  per-requester accept.
- rsp_valid  out  NUM_REQS  one-hot response valid.
- rsp_data  out  DATA_WIDTH  response data, broadcast to all requesters.
- rsp_tag  out  TAG_WIDTH  response tag with the index field stripped.
- rsp_ready  in  NUM_REQS  per-requester response ready.
- icache_req_valid  out  1  cache request valid.
- icache_req_addr  out  ADDR_WIDTH  cache request address.
- icache_req_tag  out  TAG_WIDTH+SEL_BITS  cache request tag, {req_tag, requester index}, index in the LSBs.
- icache_req_ready  in  1  cache accepts request.
- icache_rsp_valid  in  1  cache response valid.
- icache_rsp_data  in  DATA_WIDTH  cache response data.
- icache_rsp_tag  in  TAG_WIDTH+SEL_BITS  cache response tag.
- icache_rsp_ready  out  1  response accept.
- err  out  1  sticky: response carried an out-of-range index or hit a zero counter.
- busy  out  1  request stage occupied or any counter nonzero.

Behaviour:
- Reset: asynchronous, active-high; applies immediately regardless of clk.
  - Cleared on reset: request stage valid, RR pointer, all outstanding counters, err.
  - Reset values: req_ready=0, icache_req_valid=0, rsp_valid=0, busy=0, err=0.
  - Any in-flight transaction is discarded; responses arriving after reset release are handled as unexpected (see below).
- Eligibility: requester i is eligible when req_valid[i]=1 and cnt[i] < MAX_OUTST.
- Grant: combinational, first eligible index scanning from ptr upward with wrap-around. At most one req_ready bit is high.
  - req_ready[g]=1 only when the stage is empty or drains this cycle (icache_req_valid && icache_req_ready).
  - No bubble is required under back-to-back traffic.
- Accept (req_valid[g] && req_ready[g]):
  - Capture {addr, tag, g} into the stage; stage valid next cycle (latency 1).
  - ptr <= (g+1) mod NUM_REQS.
  - cnt[g] increments.
- ptr changes only on accept, so a stalled stage does not reorder fairness.
- Request stage: icache_req_* driven from registers. Contents are held stable while valid and not ready (AXI-style: valid must not drop without a handshake).
- Response routing: sel = icache_rsp_tag[SEL_BITS-1:0].
  - rsp_valid[sel] = icache_rsp_valid; icache_rsp_ready = rsp_ready[sel]; combinational, zero latency.
  - A response fire decrements cnt[sel].
- Unexpected responses: if sel >= NUM_REQS or cnt[sel]==0 when icache_rsp_valid=1:
  - icache_rsp_ready=1 (dropped).
  - No rsp_valid asserted, no counter change.
  - err set and held until reset.
- Counters: width clog2(MAX_OUTST+1).
  - Same-cycle accept and response fire on one requester: counter unchanged.
  - Cannot overflow because eligibility gates accept.
- busy = stage valid | OR of all cnt != 0. Registered-state-derived, no combinational input path.
- NUM_REQS=1: ptr is constant 0; index field is 1 bit, always 0.

Decomposition:
- Shared package: SEL_BITS/counter-width functions and the icache tag layout (index in LSBs, field widths), so the icache and arbiter agree on the tag layout.
- One sub-module: rr_arbiter (NUM_REQS; inputs: eligible vector, pointer, advance strobe; outputs: one-hot grant and index).
- Request stage, counters and response routing stay in icache_req_arbiter.

Test Plan:
- Reset mid-transfer: assert reset with the stage valid and cnt[0]=2 -> icache_req_valid, busy and all counters go to 0 immediately, without waiting for a clock edge.
- Round-robin fairness: NUM_REQS=2, both requesters valid continuously, icache_req_ready=1 -> cache sees index sequence 0,1,0,1; first icache_req_valid one cycle after first accept.
- Backpressure: icache_req_ready=0 for 5 cycles with stage full -> addr/tag stable; req_ready all 0; ptr unchanged; first accept resumes the cycle ready rises.
- Outstanding limit: MAX_OUTST=4, requester 0 issues with no responses -> 4 accepts, then req_ready[0]=0 while requester 1 is still granted; one response to requester 0 re-enables it the next cycle.
- Response routing: icache_rsp_tag={8'hA5, 1'b1}, rsp_ready[1]=0 -> rsp_valid=2'b10, rsp_tag=8'hA5, icache_rsp_ready=0; raise rsp_ready[1] -> fire, cnt[1] decrements.
- Unexpected response: response to a requester with cnt=0 -> icache_rsp_ready=1, rsp_valid=0, err=1 and stays 1.

Source files
------------

// File: rtl/icache_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icache_req_arbiter_pkg
//  Description : Shared sizing helpers and icache tag layout for the fetch
//                request arbiter. The icache echoes the tag unchanged, so both
//                sides must agree on where the requester index lives.
//                Tag layout: {requester_tag[TAG_WIDTH-1:0], index[SEL_BITS-1:0]}
//  Revision    : 1.0 - initial release
// ============================================================================
package icache_req_arbiter_pkg;

    // Bit position of the requester index inside the icache tag.
    localparam int TAG_SEL_LSB = 0;

    // Requester index width; a single requester still carries a 1-bit field.
    function automatic int calc_sel_bits(input int num_reqs);
        return (num_reqs > 1) ? $clog2(num_reqs) : 1;
    endfunction

    // Outstanding counter width, wide enough to hold MAX_OUTST itself.
    function automatic int calc_cnt_width(input int max_outst);
        return $clog2(max_outst + 1);
    endfunction

    // Total icache-side tag width.
    function automatic int calc_icache_tag_width(input int tag_width, input int sel_bits);
        return tag_width + sel_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_req_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Scans the eligible vector
//                starting at ptr with wrap-around and returns the first hit.
//                No grant is produced unless advance is high.
//  Ports       : eligible  in  NUM_REQS  candidates this cycle
//                ptr       in  SEL_BITS  highest-priority index
//                advance   in  1         downstream can take a request
//                grant     out NUM_REQS  one-hot grant (all zero if none)
//                grant_idx out SEL_BITS  binary index of the grant
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import icache_req_arbiter_pkg::*;
#(
    parameter int NUM_REQS = 2,
    localparam int SEL_BITS = calc_sel_bits(NUM_REQS)
) (
    input  logic [NUM_REQS-1:0] eligible,
    input  logic [SEL_BITS-1:0] ptr,
    input  logic                advance,
    output logic [NUM_REQS-1:0] grant,
    output logic [SEL_BITS-1:0] grant_idx
);

    logic w_found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        for (int k = 0; k < NUM_REQS; k++) begin
            int cand;
            // ptr is always < NUM_REQS, so one subtraction is enough to wrap.
            cand = int'(ptr) + k;
            if (cand >= NUM_REQS) begin
                cand = cand - NUM_REQS;
            end
            if (!w_found && advance && eligible[cand]) begin
                w_found     = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = SEL_BITS'(cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/icache_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : icache_req_arbiter
//  Description : Shares one icache request/response port among NUM_REQS fetch
//                requesters. Round-robin grant into a single registered
//                request stage, per-requester outstanding limiting, and
//                response routing by the index carried in the tag LSBs.
//  Ports       : clk, reset (async, active-high)
//                req_valid/req_addr/req_tag/req_ready   requester side
//                rsp_valid/rsp_data/rsp_tag/rsp_ready   requester responses
//                icache_req_*                            cache request port
//                icache_rsp_*                            cache response port
//                err   sticky unexpected-response flag
//                busy  stage occupied or any request in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module icache_req_arbiter
    import icache_req_arbiter_pkg::*;
#(
    parameter int NUM_REQS   = 2,
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 8,
    parameter int MAX_OUTST  = 4,
    localparam int SEL_BITS  = calc_sel_bits(NUM_REQS),
    localparam int ITAG_W    = calc_icache_tag_width(TAG_WIDTH, SEL_BITS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQS-1:0]            req_valid,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]  req_tag,
    output logic [NUM_REQS-1:0]            req_ready,
    output logic [NUM_REQS-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic [TAG_WIDTH-1:0]           rsp_tag,
    input  logic [NUM_REQS-1:0]            rsp_ready,
    output logic                           icache_req_valid,
    output logic [ADDR_WIDTH-1:0]          icache_req_addr,
    output logic [ITAG_W-1:0]              icache_req_tag,
    input  logic                           icache_req_ready,
    input  logic                           icache_rsp_valid,
    input  logic [DATA_WIDTH-1:0]          icache_rsp_data,
    input  logic [ITAG_W-1:0]              icache_rsp_tag,
    output logic                           icache_rsp_ready,
    output logic                           err,
    output logic                           busy
);

    localparam int                 CNT_W      = calc_cnt_width(MAX_OUTST);
    localparam logic [CNT_W-1:0]   C_MAX_CNT  = CNT_W'(MAX_OUTST);
    localparam logic [SEL_BITS:0]  C_NUM_REQS = (SEL_BITS + 1)'(NUM_REQS);
    localparam logic [SEL_BITS-1:0] C_LAST_IDX = SEL_BITS'(NUM_REQS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  r_stage_valid;
    logic [ADDR_WIDTH-1:0] r_stage_addr;
    logic [ITAG_W-1:0]     r_stage_tag;
    logic [SEL_BITS-1:0]   r_ptr;
    logic [CNT_W-1:0]      r_cnt [NUM_REQS];
    logic                  r_err;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] w_addr_arr [NUM_REQS];
    logic [TAG_WIDTH-1:0]  w_tag_arr  [NUM_REQS];
    logic [NUM_REQS-1:0]   w_eligible;
    logic [NUM_REQS-1:0]   w_grant;
    logic [SEL_BITS-1:0]   w_grant_idx;
    logic                  w_advance;
    logic                  w_accept;
    logic [NUM_REQS-1:0]   w_cnt_nz;
    logic [NUM_REQS-1:0]   w_rsp_fire;
    logic [SEL_BITS-1:0]   w_rsp_sel;
    logic                  w_sel_in_range;
    logic                  w_sel_cnt_zero;
    logic                  w_sel_rsp_ready;
    logic                  w_rsp_expected;

    generate
        for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_req
            assign w_addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_tag_arr[gi]  = req_tag[gi*TAG_WIDTH +: TAG_WIDTH];
            // Eligibility gating is what keeps the counters from overflowing.
            assign w_eligible[gi] = req_valid[gi] && (r_cnt[gi] < C_MAX_CNT);
            assign w_cnt_nz[gi]   = |r_cnt[gi];
        end
    endgenerate

    // The stage can be refilled in the same cycle it drains, so streaming
    // traffic sees no bubble. Grants are suppressed while reset is held.
    assign w_advance = (~r_stage_valid | icache_req_ready) & ~reset;

    rr_arbiter #(
        .NUM_REQS (NUM_REQS)
    ) u_rr (
        .eligible  (w_eligible),
        .ptr       (r_ptr),
        .advance   (w_advance),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    // A grant is only issued to an eligible (hence valid) requester, so any
    // grant bit is an accept.
    assign req_ready = w_grant;
    assign w_accept  = |w_grant;

    // ------------------------------------------------------------------
    // Request stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stage_valid <= 1'b0;
            r_stage_addr  <= '0;
            r_stage_tag   <= '0;
        end else if (w_accept) begin
            r_stage_valid <= 1'b1;
            r_stage_addr  <= w_addr_arr[w_grant_idx];
            r_stage_tag   <= {w_tag_arr[w_grant_idx], w_grant_idx};
        end else if (icache_req_ready) begin
            r_stage_valid <= 1'b0;
        end
    end

    assign icache_req_valid = r_stage_valid;
    assign icache_req_addr  = r_stage_addr;
    assign icache_req_tag   = r_stage_tag;

    // Pointer moves only on accept so a stalled stage keeps its fairness order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (w_grant_idx == C_LAST_IDX) ? '0 : w_grant_idx + SEL_BITS'(1);
        end
    end

    // ------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------
    assign w_rsp_sel      = icache_rsp_tag[TAG_SEL_LSB +: SEL_BITS];
    assign w_sel_in_range = ({1'b0, w_rsp_sel} < C_NUM_REQS);

    always_comb begin
        w_sel_cnt_zero  = 1'b1;
        w_sel_rsp_ready = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (w_rsp_sel == SEL_BITS'(i)) begin
                w_sel_cnt_zero  = (r_cnt[i] == '0);
                w_sel_rsp_ready = rsp_ready[i];
            end
        end
    end

    // A response is only routed when its requester actually has one pending;
    // anything else is swallowed so a stray response cannot wedge the cache.
    assign w_rsp_expected   = w_sel_in_range && !w_sel_cnt_zero;
    assign icache_rsp_ready = w_rsp_expected ? w_sel_rsp_ready : 1'b1;
    assign rsp_data         = icache_rsp_data;
    assign rsp_tag          = icache_rsp_tag[SEL_BITS +: TAG_WIDTH];

    generate
        for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_rsp
            assign rsp_valid[gi]  = icache_rsp_valid && w_rsp_expected &&
                                    (w_rsp_sel == SEL_BITS'(gi));
            assign w_rsp_fire[gi] = rsp_valid[gi] && rsp_ready[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outstanding counters: simultaneous accept and response cancel out.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_cnt
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt[gi] <= '0;
                end else begin
                    case ({w_grant[gi], w_rsp_fire[gi]})
                        2'b10:   r_cnt[gi] <= r_cnt[gi] + CNT_W'(1);
                        2'b01:   r_cnt[gi] <= r_cnt[gi] - CNT_W'(1);
                        default: r_cnt[gi] <= r_cnt[gi];
                    endcase
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (icache_rsp_valid && !w_rsp_expected) begin
            r_err <= 1'b1;
        end
    end

    assign err  = r_err;
    assign busy = r_stage_valid | (|w_cnt_nz);

endmodule
`default_nettype wire

// File: tb/tb_icache_req_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_icache_req_arbiter
//  Description : Self-checking bench for icache_req_arbiter (2 requesters,
//                MAX_OUTST=4). A reference model predicts grants, counters,
//                routing and err; accepted requests are queued and compared
//                against the icache request port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_req_arbiter;

    localparam int NR = 2;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int TW = 8;
    localparam int MO = 4;
    localparam int SB = 1;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [TW+SB-1:0] tag;
    } req_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*TW-1:0]  req_tag;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic [TW-1:0]     rsp_tag;
    logic [NR-1:0]     rsp_ready;
    logic              icache_req_valid;
    logic [AW-1:0]     icache_req_addr;
    logic [TW+SB-1:0]  icache_req_tag;
    logic              icache_req_ready;
    logic              icache_rsp_valid;
    logic [DW-1:0]     icache_rsp_data;
    logic [TW+SB-1:0]  icache_rsp_tag;
    logic              icache_rsp_ready;
    logic              err;
    logic              busy;

    always #5 clk = ~clk;

    icache_req_arbiter #(
        .NUM_REQS   (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TAG_WIDTH  (TW),
        .MAX_OUTST  (MO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_addr         (req_addr),
        .req_tag          (req_tag),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .rsp_tag          (rsp_tag),
        .rsp_ready        (rsp_ready),
        .icache_req_valid (icache_req_valid),
        .icache_req_addr  (icache_req_addr),
        .icache_req_tag   (icache_req_tag),
        .icache_req_ready (icache_req_ready),
        .icache_rsp_valid (icache_rsp_valid),
        .icache_rsp_data  (icache_rsp_data),
        .icache_rsp_tag   (icache_rsp_tag),
        .icache_rsp_ready (icache_rsp_ready),
        .err              (err),
        .busy             (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int   m_ptr;
    int   m_cnt [NR];
    bit   m_sv;
    bit   m_err;
    req_t sbq [$];
    int   drained [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_sv  = 0;
        m_err = 0;
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        sbq.delete();
    endtask

    // One clock: randomise payloads, check all outputs against the model,
    // advance the model, then step to 1 time unit past the next rising edge.
    task automatic cycle();
        int            g;
        int            sel;
        bit            can;
        bit            rok;
        bit            fire;
        bit            any_cnt;
        logic [NR-1:0] exp_rdy;
        logic [NR-1:0] exp_rv;
        req_t          ent;

        req_addr        = {$urandom, $urandom};
        req_tag         = 16'($urandom);
        icache_rsp_data = $urandom;
        #1;

        can = !m_sv || icache_req_ready;
        g   = -1;
        if (can) begin
            for (int k = 0; k < NR; k++) begin
                int j;
                j = (m_ptr + k) % NR;
                if (g < 0 && req_valid[j] && m_cnt[j] < MO) g = j;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", req_ready, exp_rdy);
        check("icache_req_valid", icache_req_valid, m_sv);
        if (m_sv && sbq.size() > 0) begin
            check("icache_req_addr", icache_req_addr, sbq[0].addr);
            check("icache_req_tag", icache_req_tag, sbq[0].tag);
        end

        sel    = int'(icache_rsp_tag[0]);
        rok    = icache_rsp_valid && (m_cnt[sel] != 0);
        fire   = rok && rsp_ready[sel];
        exp_rv = '0;
        if (rok) exp_rv[sel] = 1'b1;
        check("rsp_valid", rsp_valid, exp_rv);
        if (icache_rsp_valid) begin
            check("icache_rsp_ready", icache_rsp_ready, rok ? rsp_ready[sel] : 1'b1);
            check("rsp_tag", rsp_tag, icache_rsp_tag[TW+SB-1:SB]);
            check("rsp_data", rsp_data, icache_rsp_data);
        end
        any_cnt = 0;
        for (int i = 0; i < NR; i++) if (m_cnt[i] != 0) any_cnt = 1;
        check("busy", busy, m_sv || any_cnt);
        check("err", err, m_err);

        // model next state
        if (m_sv && icache_req_ready && sbq.size() > 0) begin
            drained.push_back(int'(sbq[0].tag[0]));
            void'(sbq.pop_front());
        end
        m_sv = m_sv && !icache_req_ready;
        if (g >= 0) begin
            ent.addr = req_addr[g*AW +: AW];
            ent.tag  = {req_tag[g*TW +: TW], SB'(g)};
            sbq.push_back(ent);
            m_sv  = 1;
            m_ptr = (g + 1) % NR;
            m_cnt[g]++;
        end
        if (fire) m_cnt[sel]--;
        if (icache_rsp_valid && !rok) m_err = 1;

        @(posedge clk);
        #1;
    endtask

    // Return every outstanding request and empty the stage.
    task automatic drain_all();
        req_valid        = '0;
        icache_req_ready = 1'b1;
        rsp_ready        = '1;
        for (int n = 0; n < 40; n++) begin
            int s;
            s = -1;
            for (int i = 0; i < NR; i++) if (s < 0 && m_cnt[i] != 0) s = i;
            if (s < 0 && !m_sv) break;
            icache_rsp_valid = (s >= 0);
            icache_rsp_tag   = {8'($urandom), SB'(s < 0 ? 0 : s)};
            cycle();
        end
        icache_rsp_valid = 1'b0;
        #1;
        check("drain_done_busy", busy, 1'b0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int seq [4] = '{0, 1, 0, 1};

        reset            = 1'b1;
        req_valid        = '0;
        req_addr         = '0;
        req_tag          = '0;
        rsp_ready        = '0;
        icache_req_ready = 1'b0;
        icache_rsp_valid = 1'b0;
        icache_rsp_data  = '0;
        icache_rsp_tag   = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, '0);
        check("rst_icache_req_valid", icache_req_valid, 1'b0);
        check("rst_rsp_valid", rsp_valid, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        reset = 1'b0;

        // ---- reset mid-transfer: stage valid, cnt[0]=2 ----
        req_valid = 2'b01; icache_req_ready = 1'b0;
        cycle();
        cycle();
        icache_req_ready = 1'b1;
        cycle();
        icache_req_ready = 1'b0;
        cycle();
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_icache_req_valid", icache_req_valid, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_req_ready", req_ready, '0);
        model_reset();
        req_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // ---- round-robin fairness ----
        drained.delete();
        req_valid = 2'b11; icache_req_ready = 1'b1;
        repeat (5) cycle();
        req_valid = '0;
        cycle();
        for (int i = 0; i < 4; i++) begin
            if (drained.size() > i) check($sformatf("rr_seq%0d", i), drained[i], seq[i]);
            else check($sformatf("rr_seq%0d_missing", i), drained.size(), i + 1);
        end

        // ---- response routing (cnt[1] is nonzero here) ----
        icache_rsp_valid = 1'b1;
        icache_rsp_tag   = {8'hA5, 1'b1};
        rsp_ready        = 2'b00;
        #1;
        check("route_rsp_valid", rsp_valid, 2'b10);
        check("route_rsp_tag", rsp_tag, 8'hA5);
        check("route_icache_rsp_ready", icache_rsp_ready, 1'b0);
        cycle();
        rsp_ready = 2'b10;
        #1;
        check("route_fire_ready", icache_rsp_ready, 1'b1);
        cycle();
        icache_rsp_valid = 1'b0;
        drain_all();

        // ---- backpressure: stage full, cache stalled 5 cycles ----
        req_valid = 2'b11; icache_req_ready = 1'b0; rsp_ready = '0;
        repeat (6) cycle();
        icache_req_ready = 1'b1;
        repeat (3) cycle();
        drain_all();

        // ---- outstanding limit on requester 0 ----
        req_valid = 2'b01; icache_req_ready = 1'b1; rsp_ready = '0;
        repeat (6) cycle();
        check("limit_cnt0", m_cnt[0], MO);
        req_valid = 2'b11;
        repeat (2) cycle();
        req_valid        = 2'b01;
        icache_rsp_valid = 1'b1;
        icache_rsp_tag   = {8'h3C, 1'b0};
        rsp_ready        = 2'b01;
        cycle();
        icache_rsp_valid = 1'b0;
        #1;
        check("limit_reenable", req_ready, 2'b01);
        cycle();
        drain_all();

        // ---- unexpected response to a requester with nothing pending ----
        rsp_ready        = '0;
        icache_rsp_valid = 1'b1;
        icache_rsp_tag   = {8'h11, 1'b0};
        #1;
        check("unexp_icache_rsp_ready", icache_rsp_ready, 1'b1);
        check("unexp_rsp_valid", rsp_valid, 2'b00);
        cycle();
        icache_rsp_valid = 1'b0;
        repeat (3) cycle();
        check("err_sticky", err, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
